// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store front-end: access-size encoding,
// controller state enum and small helpers used by both the controller and
// the lane-alignment logic.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE0 = 3'd1,
      ST_ISSUE1 = 3'd2,
      ST_CAPT   = 3'd3,
      ST_RESP   = 3'd4
   } lsu_state_e;

   // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
   function automatic logic [3:0] lsu_nbytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // True when the access runs past the end of its 8-byte SRAM word.
   function automatic logic lsu_crosses(input logic [2:0] off, input logic [1:0] size);
      return ({1'b0, off} + lsu_nbytes(size)) > 4'd8;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store front-end. Purely combinational:
// builds the 16-lane write mask and the lane-shifted store data spanning two
// SRAM words, flags word-crossing accesses, and extracts/extends load data
// from the {hi, lo} pair of SRAM words.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]   i_off,
   input  logic [1:0]   i_size,
   input  logic         i_unsigned,
   input  logic [63:0]  i_wdata,
   input  logic [63:0]  i_hi,
   input  logic [63:0]  i_lo,
   output logic [15:0]  o_mask16,
   output logic [127:0] o_wdata128,
   output logic         o_cross,
   output logic [63:0]  o_rdata
);

   logic [15:0] w_lane_bits;
   logic [63:0] w_raw;

   assign w_lane_bits = (16'd1 << lsu_nbytes(i_size)) - 16'd1;
   assign o_mask16    = w_lane_bits << i_off;
   assign o_wdata128  = {64'd0, i_wdata} << {i_off, 3'b000};
   assign o_cross     = lsu_crosses(i_off, i_size);

   // Bring the addressed byte to lane 0; the upper word only matters for crossers.
   assign w_raw = 64'({i_hi, i_lo} >> {i_off, 3'b000});

   // Truncate to the access size and sign- or zero-extend to 64 bits.
   always_comb begin
      o_rdata = w_raw;
      case (i_size)
         SZ_B:    o_rdata = i_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
         SZ_H:    o_rdata = i_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
         SZ_W:    o_rdata = i_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
         default: o_rdata = w_raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end for the 64-bit unified data SRAM. Accepts one sized
// load/store at a time, turns it into byte-lane SRAM accesses and returns an
// aligned, extended single-cycle response.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
// into two SRAM accesses; without it crossing accesses return resp_err.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              sram_en,
   output logic [7:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [XLEN-1:0]   sram_wdata,
   input  logic [XLEN-1:0]   sram_rdata
);

   lsu_state_e        r_state;
   lsu_state_e        w_state_next;

   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_we;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_resp_rdata;
   logic              r_err;

   logic [ADDR_W-1:0] w_aligned_addr;
   logic [15:0]       w_mask16;
   logic [127:0]      w_wdata128;
   logic              w_cross;
   logic [XLEN-1:0]   w_hi;
   logic [XLEN-1:0]   w_lo;
   logic [XLEN-1:0]   w_load_data;
   logic              w_req_cross;
   logic              w_req_err;
   logic              w_unused;

   // Crossing test on the incoming request decides the error path in IDLE.
   assign w_req_cross = lsu_crosses(req_addr[2:0], req_size);

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [XLEN-1:0] r_hi;

   assign w_req_err = 1'b0;
   // In CAPT the second word is arriving on sram_rdata right now.
   assign w_hi      = w_cross ? sram_rdata : '0;
   assign w_lo      = w_cross ? r_lo : sram_rdata;
   // r_hi mirrors the high word for debug visibility; extraction reads it live.
   assign w_unused  = ^{w_req_cross, r_hi};
`else
   assign w_req_err = w_req_cross;
   assign w_hi      = '0;
   assign w_lo      = sram_rdata;
   // Second-word lanes are never issued when splitting is compiled out.
   assign w_unused  = ^{w_req_cross, w_cross, w_mask16[15:8], w_wdata128[127:64], r_lo};
`endif

   assign w_aligned_addr = {r_addr[ADDR_W-1:3], 3'b000};

   lsu_align u_align (
      .i_off      (r_addr[2:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_wdata    (r_wdata),
      .i_hi       (w_hi),
      .i_lo       (w_lo),
      .o_mask16   (w_mask16),
      .o_wdata128 (w_wdata128),
      .o_cross    (w_cross),
      .o_rdata    (w_load_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Latch the request fields on acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
      end else if (r_state == ST_IDLE && req_valid) begin
         r_addr     <= req_addr;
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_we       <= req_we;
         r_wdata    <= req_wdata;
      end
   end

   // Read buffers, error flag and the held response data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lo         <= '0;
         r_resp_rdata <= '0;
         r_err        <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         r_hi         <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_err <= w_req_err;
                  if (w_req_err) begin
                     r_resp_rdata <= '0;
                  end
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ISSUE1: begin
               r_lo <= sram_rdata;
            end
`endif
            ST_CAPT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
               if (w_cross) begin
                  r_hi <= sram_rdata;
               end else begin
                  r_lo <= sram_rdata;
               end
`else
               r_lo <= sram_rdata;
`endif
               r_resp_rdata <= r_we ? '0 : w_load_data;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and SRAM request decode; SRAM outputs come only from latched state.
   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      sram_en      = 1'b0;
      sram_we      = '0;
      sram_addr    = '0;
      sram_wdata   = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = w_req_err ? ST_RESP : ST_ISSUE0;
            end
         end
         ST_ISSUE0: begin
            sram_en    = 1'b1;
            sram_addr  = w_aligned_addr;
            sram_we    = r_we ? w_mask16[7:0] : 8'd0;
            sram_wdata = w_wdata128[63:0];
`ifdef LSU_MISALIGN_SPLIT_EN
            w_state_next = w_cross ? ST_ISSUE1 : ST_CAPT;
`else
            w_state_next = ST_CAPT;
`endif
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_ISSUE1: begin
            sram_en      = 1'b1;
            sram_addr    = w_aligned_addr + ADDR_W'(8);
            sram_we      = r_we ? w_mask16[15:8] : 8'd0;
            sram_wdata   = w_wdata128[127:64];
            w_state_next = ST_CAPT;
         end
`endif
         ST_CAPT: begin
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign resp_valid = (r_state == ST_RESP);
   assign resp_err   = (r_state == ST_RESP) && r_err;
   assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed cases plus randomized traffic
// against a byte-addressed reference memory. Follows LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        sram_en;
   logic [7:0]  sram_we;
   logic [63:0] sram_addr;
   logic [63:0] sram_wdata;
   logic [63:0] sram_rdata = '0;

   lsu_mem_ctrl #(.ADDR_W(64), .XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] rdata;
      bit          err;
      int          nen;
      int          lat;
      int          cyc;
      int          id;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          en_cnt = 0;
   int          next_id = 0;
   logic [7:0]  ref_mem[logic [63:0]];
   logic [63:0] sram_mem[logic [63:0]];
   logic [63:0] sram_tmp;
   logic [7:0]  log_we[$];
   logic [63:0] log_addr[$];
   logic [63:0] log_wdata[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: one-cycle registered read, byte-lane writes.
   always @(posedge clk) begin
      if (sram_en) begin
         sram_tmp = sram_mem.exists(sram_addr >> 3) ? sram_mem[sram_addr >> 3] : 64'd0;
         sram_rdata <= sram_tmp;
         for (int b = 0; b < 8; b++)
            if (sram_we[b]) sram_tmp[8*b +: 8] = sram_wdata[8*b +: 8];
         sram_mem[sram_addr >> 3] = sram_tmp;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Reference: byte-granular memory, sizes and extension from the access rules.
   task automatic ref_access(input bit we, input logic [1:0] sz, input bit uns,
                             input logic [63:0] addr, input logic [63:0] wd, output exp_t e);
      int n;
      int off;
      bit crossing;
      logic [63:0] v;
      n = 1 << sz;
      off = int'(addr % 64'd8);
      crossing = (off + n) > 8;
      e.err = 1'b0;
      e.rdata = '0;
      e.nen = crossing ? 2 : 1;
      e.lat = crossing ? 4 : 3;
      e.cyc = 0;
      e.id = 0;
`ifndef LSU_MISALIGN_SPLIT_EN
      if (crossing) begin
         e.err = 1'b1;
         e.nen = 0;
         e.lat = 1;
         return;
      end
`endif
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < n; i++)
            if (ref_mem.exists(addr + 64'(i))) v[8*i +: 8] = ref_mem[addr + 64'(i)];
         if (!uns && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
         e.rdata = v;
      end
   endtask

   // Drive a request (called at a negedge) and return at the negedge after acceptance.
   task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd, output int acc);
      exp_t e;
      int w;
      req_valid = 1'b1;
      req_we = we;
      req_size = sz;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wd;
      w = 0;
      while (req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (req_ready !== 1'b1) begin
         chk("accept_timeout", {63'd0, req_ready}, 64'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      ref_access(we, sz, uns, addr, wd, e);
      e.cyc = acc + e.lat - 1;
      e.id = next_id;
      next_id++;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic clear_log();
      log_we.delete();
      log_addr.delete();
      log_wdata.delete();
   endtask

   // Monitor: SRAM activity log, idle-output rule, and response scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         en_cnt = 0;
      end else begin
         if (sram_en) begin
            en_cnt++;
            log_we.push_back(sram_we);
            log_addr.push_back(sram_addr);
            log_wdata.push_back(sram_wdata);
         end else begin
            chk("sram_idle_zero", {63'd0, (|sram_we) || (|sram_addr) || (|sram_wdata)}, 64'd0);
         end
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               $display("resp id=%0d cyc=%0d rdata=0x%016h err=%0d", e.id, cyc, resp_rdata, resp_err);
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
               chk("resp_cycle", 64'(cyc), 64'(e.cyc));
               chk("sram_en_count", 64'(en_cnt), 64'(e.nen));
            end
            en_cnt = 0;
         end
      end
   end

   initial begin
      int a1;
      int a2;
      bit we;
      logic [1:0] sz;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
      chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("reset_resp_err", {63'd0, resp_err}, 64'd0);
      chk("reset_resp_rdata", resp_rdata, 64'd0);
      chk("reset_sram_en", {63'd0, sram_en}, 64'd0);

      // Dword store then load.
      clear_log();
      issue(1'b1, 2'd3, 1'b0, 64'h1000, 64'h1122334455667788, a1);
      drain();
      chk("st_d_nacc", 64'(log_we.size()), 64'd1);
      if (log_we.size() > 0) begin
         chk("st_d_we", {56'd0, log_we[0]}, 64'hFF);
         chk("st_d_addr", log_addr[0], 64'h1000);
      end
      issue(1'b0, 2'd3, 1'b0, 64'h1000, 64'h0, a1);
      drain();

      // Byte store at lane 5, signed and unsigned loads.
      clear_log();
      issue(1'b1, 2'd0, 1'b0, 64'h1005, 64'h80, a1);
      drain();
      chk("st_b_nacc", 64'(log_we.size()), 64'd1);
      if (log_we.size() > 0) begin
         chk("st_b_we", {56'd0, log_we[0]}, 64'h20);
         chk("st_b_wdata", log_wdata[0], 64'h0000800000000000);
      end
      issue(1'b0, 2'd0, 1'b0, 64'h1005, 64'h0, a1);
      issue(1'b0, 2'd0, 1'b1, 64'h1005, 64'h0, a1);
      drain();

      // Word store crossing into the next SRAM word.
      clear_log();
      issue(1'b1, 2'd2, 1'b0, 64'h1006, 64'hAABBCCDD, a1);
      drain();
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("split_nacc", 64'(log_we.size()), 64'd2);
      if (log_we.size() > 1) begin
         chk("split_we0", {56'd0, log_we[0]}, 64'hC0);
         chk("split_addr0", log_addr[0], 64'h1000);
         chk("split_we1", {56'd0, log_we[1]}, 64'h03);
         chk("split_addr1", log_addr[1], 64'h1008);
      end
`else
      chk("cross_nacc", 64'(log_we.size()), 64'd0);
`endif
      issue(1'b0, 2'd2, 1'b0, 64'h1006, 64'h0, a1);
      issue(1'b0, 2'd1, 1'b0, 64'h2007, 64'h0, a1);
      drain();

      // Reset while the first SRAM access is being issued.
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'd3;
      req_addr = 64'h1000;
      a1 = 0;
      while (req_ready !== 1'b1 && a1 < 50) begin
         @(negedge clk);
         a1++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_issue0_en", {63'd0, sram_en}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_sram_en_low", {63'd0, sram_en}, 64'd0);
      chk("rst_no_resp", {63'd0, resp_valid}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      repeat (6) @(negedge clk);

      // Back-to-back loads with req_valid held high.
      issue(1'b0, 2'd3, 1'b0, 64'h1000, 64'h0, a1);
      issue(1'b0, 2'd2, 1'b1, 64'h1004, 64'h0, a2);
      chk("b2b_accept_gap", 64'(a2 - a1), 64'd4);
      drain();

      // Randomized mix over a small window so loads hit earlier stores.
      for (int i = 0; i < 200; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         issue(we, sz, 1'($urandom_range(0, 1)), 64'h1000 + 64'($urandom_range(0, 63)),
               {$urandom, $urandom}, a1);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
